// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: synchronizes the column lines, debounces press and
// release on a slow scan tick, and reports one key code per accepted press.
//
// state     | meaning
// IDLE      | all rows driven low, waiting for any column to go low
// PRESS_DEB | a column is low, counting stable ticks before scanning
// SCAN      | walking one low row at a time to locate the key
// HELD      | key accepted, its row stays driven, waiting for release
// REL_DEB   | columns all high, counting stable ticks before dropping key_down
module keypad_scanner #(
    parameter int F_CLK     = 50000000,
    parameter int F_SCAN    = 1000,
    parameter int DEB_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int TICK_DIV = F_CLK / F_SCAN;
    localparam int DIV_W    = $clog2(TICK_DIV);
    localparam int DEB_W    = $clog2(DEB_TICKS + 1);

    typedef enum logic [2:0] {IDLE, PRESS_DEB, SCAN, HELD, REL_DEB} state_t;

    state_t             state;
    logic [3:0]         col_meta;
    logic [3:0]         col_s;
    logic [DIV_W-1:0]   div_cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic [1:0]         row_idx;
    logic               tick;
    logic               any_low;
    logic               deb_done;
    logic [DEB_W-1:0]   deb_inc;

    function automatic logic [1:0] low_col(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    assign tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign any_low  = (col_s != 4'hF);
    assign deb_done = (deb_cnt >= DEB_W'(DEB_TICKS - 1));
    assign deb_inc  = (deb_cnt == DEB_W'(DEB_TICKS)) ? deb_cnt : deb_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || tick) div_cnt <= '0;
        else                div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= 4'b0000;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            deb_cnt   <= '0;
            row_idx   <= 2'd0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        row <= 4'b0000;
                        if (any_low) begin
                            state   <= PRESS_DEB;
                            deb_cnt <= '0;
                        end
                    end
                    PRESS_DEB: begin
                        if (!any_low) begin
                            state <= IDLE;
                        end else begin
                            deb_cnt <= deb_inc;
                            if (deb_done) begin
                                state   <= SCAN;
                                row_idx <= 2'd0;
                                row     <= 4'b1110;
                            end
                        end
                    end
                    SCAN: begin
                        // col_s here reflects the row driven on the previous tick
                        if (any_low) begin
                            key_code  <= {row_idx, low_col(col_s)};
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            state     <= HELD;
                        end else if (row_idx == 2'd3) begin
                            state <= IDLE;
                            row   <= 4'b0000;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                            row     <= ~(4'b0001 << (row_idx + 2'd1));
                        end
                    end
                    HELD: begin
                        if (!any_low) begin
                            state   <= REL_DEB;
                            deb_cnt <= '0;
                        end
                    end
                    REL_DEB: begin
                        if (any_low) begin
                            state <= HELD;
                        end else begin
                            deb_cnt <= deb_inc;
                            if (deb_done) begin
                                state    <= IDLE;
                                key_down <= 1'b0;
                                row      <= 4'b0000;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 switch matrix
// (TICK_DIV = 10 clocks, DEB_TICKS = 4).
module tb_keypad_scanner;
    logic       clk;
    logic       rst_n;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    keypad_scanner #(.F_CLK(1000), .F_SCAN(100), .DEB_TICKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .col(col), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // closed switch connects its row to its column; columns pulled up
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    always @(negedge clk) if (key_valid) vcount++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;
    bit seen;

    initial begin
        rst_n = 1'b0;
        keys  = 16'h0;
        clks(3);
        chk("rst_row", row, 4'b0000);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_down", key_down, 1'b0);
        rst_n = 1'b1;
        clks(30);
        chk("idle_no_valid", vcount, 0);

        // stable press row 2 / col 1
        keys = 16'h0200;
        clks(200);
        chk("k9_count", vcount, 1);
        chk("k9_code", key_code, 4'h9);
        chk("k9_down", key_down, 1'b1);
        chk("k9_row", row, 4'b1011);
        keys = 16'h0;
        clks(20);
        chk("k9_down_during_reldeb", key_down, 1'b1);
        clks(60);
        chk("k9_released", key_down, 1'b0);
        chk("k9_idle_row", row, 4'b0000);
        chk("k9_count_after", vcount, 1);

        // bouncing press row 1 / col 1, then stable
        base = vcount;
        for (int i = 0; i < 2; i++) begin
            keys = 16'h0020; clks(20);
            keys = 16'h0000; clks(10);
        end
        chk("bounce_no_valid", vcount, base);
        chk("bounce_no_down", key_down, 1'b0);
        keys = 16'h0020;
        clks(150);
        chk("bounce_count", vcount, base + 1);
        chk("bounce_code", key_code, 4'h5);
        chk("bounce_row", row, 4'b1101);
        keys = 16'h0;
        clks(100);
        chk("bounce_released", key_down, 1'b0);

        // two keys: row1/col3 and row3/col0
        base = vcount;
        keys = 16'h1080;
        clks(200);
        chk("multi_count", vcount, base + 1);
        chk("multi_code", key_code, 4'h7);
        chk("multi_row", row, 4'b1101);
        keys = 16'h0;
        clks(100);
        chk("multi_released", key_down, 1'b0);

        // release during scan, before row 3 is sampled
        base = vcount;
        keys = 16'h4000;
        seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge clk);
            if (row == 4'b1110) seen = 1'b1;
        end
        chk("midscan_scan_seen", seen, 1'b1);
        keys = 16'h0;
        clks(100);
        chk("midscan_no_valid", vcount, base);
        chk("midscan_no_down", key_down, 1'b0);
        chk("midscan_idle_row", row, 4'b0000);

        // reset while holding key F
        base = vcount;
        keys = 16'h8000;
        clks(200);
        chk("kf_count", vcount, base + 1);
        chk("kf_code", key_code, 4'hF);
        chk("kf_down", key_down, 1'b1);
        rst_n = 1'b0;
        clks(1);
        rst_n = 1'b1;
        chk("kf_rst_code", key_code, 4'h0);
        chk("kf_rst_down", key_down, 1'b0);
        chk("kf_rst_row", row, 4'b0000);
        chk("kf_rst_valid", key_valid, 1'b0);
        clks(200);
        chk("kf_redetect_count", vcount, base + 2);
        chk("kf_redetect_code", key_code, 4'hF);
        chk("kf_redetect_down", key_down, 1'b1);
        keys = 16'h0;
        clks(100);
        chk("kf_released", key_down, 1'b0);

        // one-tick release glitch while held on row 0 / col 2
        base = vcount;
        keys = 16'h0004;
        clks(200);
        chk("k2_count", vcount, base + 1);
        chk("k2_code", key_code, 4'h2);
        chk("k2_row", row, 4'b1110);
        keys = 16'h0; clks(10);
        keys = 16'h0004;
        clks(100);
        chk("glitch_down", key_down, 1'b1);
        chk("glitch_no_repeat", vcount, base + 1);
        keys = 16'h0;
        clks(100);
        chk("glitch_released", key_down, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
